seg_scanner: RTL and testbench

SEG_SCANNER -- requirements
Module: seg_scanner

---
 rtl/seg_pkg.sv | 10 +
 rtl/bcd_to_seg.sv | 9 +
 rtl/seg_scanner.sv | 76 +++++++
 tb/tb_seg_scanner.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared digit count, seven-segment patterns (gfedcba, active-high) and blank code
package seg_pkg;
    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] BLANK = 7'h00;
    localparam logic [6:0] SEG_PAT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    typedef logic [3:0] nibble_t;
endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational hex nibble to active-high gfedcba segment decoder
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = SEG_PAT[nib];
endmodule

// File: rtl/seg_scanner.sv
// seg_scanner: 4-digit multiplexed display scanner, frame-synchronous updates; SEG_SCANNER_LEADING_ZERO_BLANK_EN blanks leading zeros
module seg_scanner
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    output logic        pending,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_tick
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [15:0]   disp_q, disp_d, shadow_q, shadow_d;
    logic          pending_q, pending_d, tick_q, tick_d;
    logic [6:0]    seg_q, seg_d, dec;
    logic [3:0]    an_q, an_d;
    logic          tc, boundary, blank;
    nibble_t       nib;

    bcd_to_seg u_dec (.nib(nib), .seg(dec));

    always_comb begin
        tc        = cnt_q == CW'(REFRESH_DIV - 1);
        boundary  = tc && idx_q == IW'(NUM_DIGITS - 1);
        cnt_d     = tc ? '0 : cnt_q + 1'b1;
        idx_d     = tc ? idx_q + 1'b1 : idx_q;
        shadow_d  = load ? value : shadow_q;
        // display only moves at a frame boundary; a coincident load stays pending for the next one
        disp_d    = (boundary && pending_q) ? shadow_q : disp_q;
        pending_d = load || (pending_q && !boundary);
        tick_d    = boundary;
        nib       = disp_q[{idx_q, 2'b00} +: 4];
`ifdef SEG_SCANNER_LEADING_ZERO_BLANK_EN
        blank     = idx_q != '0 && (disp_q >> {idx_q, 2'b00}) == '0;
`else
        blank     = 1'b0;
`endif
        an_d      = 4'b0001 << idx_q;
        seg_d     = blank ? BLANK : dec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            disp_q    <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
            seg_q     <= '0;
            an_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign pending    = pending_q;
    assign frame_tick = tick_q;
    assign seg        = seg_q;
    assign an         = an_q;
endmodule

// File: tb/tb_seg_scanner.sv
// tb_seg_scanner: directed scoreboard bench for seg_scanner with REFRESH_DIV=4
module tb_seg_scanner;
    logic        clk = 1'b0;
    logic        reset, load, pending, frame_tick;
    logic [15:0] value;
    logic [6:0]  seg;
    logic [3:0]  an;
    int n_assert = 0;
    int n_fail = 0;

    typedef struct packed { logic [3:0] an; logic [6:0] seg; } slot_t;
    slot_t exp_q[$];
    logic [6:0] pat [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    seg_scanner #(.REFRESH_DIV(4)) dut (
        .clk(clk), .reset(reset), .load(load), .value(value),
        .pending(pending), .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void push_frame(input logic [15:0] v);
        for (int i = 0; i < 4; i++) begin
            slot_t e;
            e.an  = 4'(1 << i);
            e.seg = pat[v[4*i +: 4]];
`ifdef SEG_SCANNER_LEADING_ZERO_BLANK_EN
            if (i > 0 && (v >> (4 * i)) == 16'h0) e.seg = 7'h00;
`endif
            exp_q.push_back(e);
        end
    endfunction

    task automatic wait_tick();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (frame_tick) break;
        end
        chk("frame_tick_seen", 16'(frame_tick), 16'h1);
    endtask

    task automatic check_frame();
        slot_t e;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) repeat (4) @(negedge clk);
            e = exp_q.pop_front();
            chk("slot_an", 16'(an), 16'(e.an));
            chk("slot_seg", 16'(seg), 16'(e.seg));
        end
    endtask

    initial begin
        int ticks;
        reset = 1'b1; load = 1'b0; value = '0;
        repeat (3) @(negedge clk);
        chk("rst_an", 16'(an), 16'h0);
        chk("rst_seg", 16'(seg), 16'h0);
        chk("rst_pending", 16'(pending), 16'h0);
        chk("rst_tick", 16'(frame_tick), 16'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_an", 16'(an), 16'h1);
        chk("rel_seg", 16'(seg), 16'h3F);
        repeat (4) @(negedge clk);
        chk("slot1_an", 16'(an), 16'h2);
        chk("slot1_seg", 16'(seg), 16'h3F);

        load = 1'b1; value = 16'h1234;
        @(negedge clk);
        load = 1'b0; value = '0;
        chk("load_pending", 16'(pending), 16'h1);
        chk("hold_seg", 16'(seg), 16'h3F);
        push_frame(16'h1234);
        wait_tick();
        chk("clear_pending", 16'(pending), 16'h0);
        check_frame();

        load = 1'b1; value = 16'h1111;
        @(negedge clk);
        value = 16'h2222;
        @(negedge clk);
        load = 1'b0;
        push_frame(16'h2222);
        wait_tick();
        check_frame();

        load = 1'b1; value = 16'h5678;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        load = 1'b1; value = 16'h9ABC;
        @(negedge clk);
        load = 1'b0;
        chk("coinc_tick", 16'(frame_tick), 16'h1);
        chk("coinc_pending", 16'(pending), 16'h1);
        push_frame(16'h5678);
        check_frame();
        push_frame(16'h9ABC);
        wait_tick();
        chk("coinc_clear", 16'(pending), 16'h0);
        check_frame();

        load = 1'b1; value = 16'h0070;
        @(negedge clk);
        load = 1'b0;
        push_frame(16'h0070);
        wait_tick();
        check_frame();

        wait_tick();
        chk("idle_pending", 16'(pending), 16'h0);
        load = 1'b1; value = 16'h8888;
        @(negedge clk);
        load = 1'b0;
        chk("mid_pending", 16'(pending), 16'h1);
        for (int i = 0; i < 32 && an !== 4'b0100; i++) @(negedge clk);
        chk("reach_idx2", 16'(an), 16'h4);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_an", 16'(an), 16'h0);
        chk("mrst_seg", 16'(seg), 16'h0);
        chk("mrst_pending", 16'(pending), 16'h0);
        ticks = 0;
        for (int i = 0; i < 6; i++) begin
            if (frame_tick) ticks++;
            @(negedge clk);
        end
        chk("mrst_no_tick", 16'(ticks), 16'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("mrel_an", 16'(an), 16'h1);
        chk("mrel_seg", 16'(seg), 16'h3F);
        push_frame(16'h0000);
        wait_tick();
        chk("abandon_pending", 16'(pending), 16'h0);
        check_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
